// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32M multi-cycle multiply/divide unit for the EX stage.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply; divide stays iterative.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [6:0]      ex_func7,
  input  logic [XLEN-1:0] ex_reg1,
  input  logic [XLEN-1:0] ex_reg2,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  output logic            stall_req,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_wd,
  output logic            md_wreg
);

  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_func3;
  logic                r_neg_q, r_neg_r;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_wd;
  logic                r_wreg;

  logic                w_is_md, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic                w_div0, w_ovf, w_special, w_fast;
  logic [XLEN-1:0]     w_special_res, w_fast_res;
  logic [XLEN:0]       w_sum, w_dhi;
  logic                w_ge;
  logic [XLEN-1:0]     w_sub;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_step, w_prod;
  logic [XLEN-1:0]     w_q, w_r, w_fin;
  logic                w_unused_stall;

  assign w_unused_stall = ^{stall[5:4], stall[2:0]};

  // Decode: is_md and operand signedness per func3.
  assign w_is_md  = (ex_opcode == 7'b0110011) && (ex_func7 == 7'b0000001);
  assign w_is_div = ex_func3[2];
  assign w_sgn1   = w_is_div ? ~ex_func3[0] : (ex_func3[1:0] != 2'b11);
  assign w_sgn2   = w_is_div ? ~ex_func3[0] : ~ex_func3[1];
  assign w_neg1   = w_sgn1 & ex_reg1[XLEN-1];
  assign w_neg2   = w_sgn2 & ex_reg2[XLEN-1];
  assign w_mag1   = w_neg1 ? -ex_reg1 : ex_reg1;
  assign w_mag2   = w_neg2 ? -ex_reg2 : ex_reg2;

  assign w_div0    = w_is_div && (ex_reg2 == '0);
  assign w_ovf     = w_is_div && ~ex_func3[0] && (ex_reg1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (ex_reg2 == '1);
  assign w_special = w_div0 | w_ovf;
  always_comb begin
    w_special_res = '0;
    if (ex_func3[1]) w_special_res = w_div0 ? ex_reg1 : '0;
    else             w_special_res = w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_op1x, w_op2x, w_fprod;
  assign w_op1x     = {{XLEN{w_sgn1 & ex_reg1[XLEN-1]}}, ex_reg1};
  assign w_op2x     = {{XLEN{w_sgn2 & ex_reg2[XLEN-1]}}, ex_reg2};
  assign w_fprod    = w_op1x * w_op2x;
  assign w_fast     = ~w_is_div;
  assign w_fast_res = (ex_func3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  // Shift-add multiply step: acc = {partial_hi, remaining multiplier bits}.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient bits}.
  assign w_dhi      = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = w_dhi >= {1'b0, r_opb};
  assign w_sub      = w_dhi[XLEN-1:0] - r_opb;
  assign w_div_next = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                           : {w_dhi[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  assign w_step = r_func3[2] ? w_div_next : w_mul_next;
  assign w_prod = r_neg_q ? -w_step : w_step;
  assign w_q    = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
  assign w_r    = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

  always_comb begin
    w_fin = '0;
    if (r_func3[2])                w_fin = r_func3[1] ? w_r : w_q;
    else if (r_func3[1:0] == 2'b00) w_fin = w_prod[XLEN-1:0];
    else                           w_fin = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall_req = 1'b0;
    md_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          stall_req = 1'b1;
          w_next    = (w_special || w_fast) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        md_valid = 1'b1;
        if (stall[3] == NO_STOP) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_func3  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_func3 <= ex_func3;
            r_wd    <= ex_wd;
            r_wreg  <= ex_wreg;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_cnt   <= CNT_W'(XLEN);
            r_acc   <= w_is_div ? {{XLEN{1'b0}}, w_mag1} : {{XLEN{1'b0}}, w_mag2};
            r_opb   <= w_is_div ? w_mag2 : w_mag1;
            if (w_special)   r_result <= w_special_res;
            else if (w_fast) r_result <= w_fast_res;
          end
        end
        S_BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_result <= w_fin;
        end
        default: ;
      endcase
    end
  end

  assign md_result = md_valid ? r_result : '0;
  assign md_wd     = md_valid ? r_wd : '0;
  assign md_wreg   = md_valid & r_wreg;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - Self-checking bench for ex_muldiv: vector table, random ops vs model, hold and reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [6:0]  ex_opcode, ex_func7;
  logic [2:0]  ex_func3;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic        stall_req, md_valid, md_wreg;
  logic [31:0] md_result;
  logic [4:0]  md_wd;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .stall_req(stall_req), .md_valid(md_valid), .md_result(md_result),
    .md_wd(md_wd), .md_wreg(md_wreg)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from plain 64-bit arithmetic and the RV32M rules.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    logic [4:0] wd;
    logic       wr;
    int         lat, scnt;
    bit         got;
    wd = 5'($urandom_range(1, 31));
    wr = 1'($urandom_range(0, 1));
    @(negedge clk);
    stall     = 6'b0;
    ex_opcode = 7'b0110011;
    ex_func7  = 7'b0000001;
    ex_func3  = f3;
    ex_reg1   = a;
    ex_reg2   = b;
    ex_wd     = wd;
    ex_wreg   = wr;
    #1;
    chk("stall_req_t0", 32'(stall_req), 32'd1);
    scnt = 1;
    lat  = 0;
    got  = 0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      #1;
      lat++;
      if (md_valid) got = 1;
      else if (stall_req) scnt++;
    end
    if (!got) begin
      chk("md_valid_timeout", 32'd0, 32'd1);
    end else begin
      chk("md_result", md_result, exp);
      chk("md_wd", 32'(md_wd), 32'(wd));
      chk("md_wreg", 32'(md_wreg), 32'(wr));
      chk("latency", 32'(lat), 32'(exp_lat(f3, a, b)));
      chk("stall_cycles", 32'(scnt), 32'(exp_lat(f3, a, b)));
      chk("stall_req_done", 32'(stall_req), 32'd0);
      if (hold > 0) begin
        stall = 6'b001000;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          #1;
          chk("hold_valid", 32'(md_valid), 32'd1);
          chk("hold_result", md_result, exp);
          chk("hold_wd", 32'(md_wd), 32'(wd));
        end
        stall = 6'b0;
      end
    end
    ex_opcode = 7'b0;
    ex_func7  = 7'b0;
    @(negedge clk);
    #1;
    chk("idle_valid", 32'(md_valid), 32'd0);
    chk("idle_stall", 32'(stall_req), 32'd0);
  endtask

  vec_t vt[$];

  initial begin
    int vcnt;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vt.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
    vt.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF});
    vt.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000});
    vt.push_back('{3'd0, 32'h12345678, 32'h10,       32'h23456780});
    vt.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vt.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vt.push_back('{3'd5, 32'd100,      32'd7,        32'd14});
    vt.push_back('{3'd7, 32'd100,      32'd7,        32'd2});
    vt.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF});
    vt.push_back('{3'd6, 32'd5,        32'd0,        32'd5});
    vt.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF});
    vt.push_back('{3'd7, 32'd5,        32'd0,        32'd5});
    vt.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vt.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0});
    vt.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0});
    vt.push_back('{3'd7, 32'hFFFFFFFF, 32'h10,       32'hF});

    rst = 1'b1; stall = '0; ex_opcode = '0; ex_func3 = '0; ex_func7 = '0;
    ex_reg1 = '0; ex_reg2 = '0; ex_wd = '0; ex_wreg = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(md_valid), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_wd", 32'(md_wd), 32'd0);

    // Non-M R-type (ADD) must be ignored.
    @(negedge clk);
    ex_opcode = 7'b0110011; ex_func7 = 7'b0000000; ex_reg1 = 32'd3; ex_reg2 = 32'd4; ex_wd = 5'd9; ex_wreg = 1'b1;
    #1;
    chk("nonmd_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    #1;
    chk("nonmd_valid", 32'(md_valid), 32'd0);
    chk("nonmd_wreg", 32'(md_wreg), 32'd0);
    ex_opcode = '0;

    foreach (vt[i]) run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, 0);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      run_op(f3, a, b, ref_md(f3, a, b), 0);
    end

    // Downstream stall holds the result in DONE.
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 4);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 3);

    // Reset mid-BUSY aborts with no result.
    @(negedge clk);
    ex_opcode = 7'b0110011; ex_func7 = 7'b0000001; ex_func3 = 3'd5;
    ex_reg1 = 32'd1000; ex_reg2 = 32'd3; ex_wd = 5'd7; ex_wreg = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    ex_opcode = '0; ex_func7 = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(md_valid), 32'd0);
    chk("abort_stall", 32'(stall_req), 32'd0);
    chk("abort_result", md_result, 32'd0);
    chk("abort_wd", 32'(md_wd), 32'd0);
    chk("abort_wreg", 32'(md_wreg), 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (md_valid) vcnt++;
    end
    chk("abort_no_pulse", 32'(vcnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
